uart_mmio: RTL

Memory-mapped UART peripheral on the CPU data bus, downstream of the core's memAddr/memWriteData/wrMask/memWr/memReadData interface. An external address decoder selects it and supplies the word offset. It serialises stored bytes through a TX FIFO onto txd and deserialises rxd into an RX FIFO. Reads are combinational, so the single-cycle core can consume them in the same cycle.

---
 rtl/uart_mmio.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with TX and RX byte FIFOs.
// Register reads are combinational; a DATA read pops RX at the clock edge.
module uart_mmio #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        re,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  wrMask,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rxState_t;

    logic isData, isStatus, isDiv;
    assign isData   = sel && (addr == 2'd0);
    assign isStatus = sel && (addr == 2'd1);
    assign isDiv    = sel && (addr == 2'd2);

    logic unusedBits;
    assign unusedBits = &{1'b0, writeData[31:16], wrMask[3:2]};

    logic [15:0] divReg, divMerged, divMinus1, halfMinus1;
    assign divMinus1  = divReg - 16'd1;
    assign halfMinus1 = {1'b0, divReg[15:1]} - 16'd1;
    assign divMerged  = {
        wrMask[1] ? writeData[15:8] : divReg[15:8],
        wrMask[0] ? writeData[7:0]  : divReg[7:0]
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            divReg <= 16'(DEFAULT_DIV);
        end else if (isDiv && we) begin
            divReg <= (divMerged < 16'd4) ? 16'd4 : divMerged;
        end
    end

    logic [7:0]  txMem [FIFO_DEPTH];
    logic [AW:0] txWrPtr, txRdPtr;
    logic        txFull, txEmpty, txPush, txPop;

    assign txEmpty = (txWrPtr == txRdPtr);
    assign txFull  = (txWrPtr[AW] != txRdPtr[AW])
                  && (txWrPtr[AW-1:0] == txRdPtr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO may land.
    assign txPush  = isData && we && wrMask[0] && (!txFull || txPop);

    always_ff @(posedge clk) begin
        if (reset) begin
            txWrPtr <= '0;
            txRdPtr <= '0;
        end else begin
            if (txPush) txWrPtr <= txWrPtr + PTR_ONE;
            if (txPop)  txRdPtr <= txRdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (txPush) txMem[txWrPtr[AW-1:0]] <= writeData[7:0];
    end

    txState_t    txState, txNext;
    logic [15:0] txCnt;
    logic [2:0]  txBit;
    logic [7:0]  txShift;
    logic        txTick, txLoad;

    assign txTick = (txCnt == 16'd0);

    always_comb begin
        txNext = txState;
        txPop  = 1'b0;
        case (txState)
            TX_IDLE: begin
                if (!txEmpty) begin
                    txPop  = 1'b1;
                    txNext = TX_START;
                end
            end
            TX_START: if (txTick) txNext = TX_DATA;
            TX_DATA: if (txTick && txBit == 3'd7) txNext = TX_STOP;
            TX_STOP: begin
                if (txTick) begin
                    txPop  = !txEmpty;
                    txNext = txEmpty ? TX_IDLE : TX_START;
                end
            end
            default: txNext = TX_IDLE;
        endcase
    end

    assign txLoad = txPop
        || (txTick && (txNext == TX_DATA || txNext == TX_STOP));

    always_ff @(posedge clk) begin
        if (reset) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
        end else begin
            txState <= txNext;
            if (txLoad) txCnt <= divMinus1;
            else if (!txTick) txCnt <= txCnt - 16'd1;
            if (txState == TX_START) txBit <= '0;
            else if (txState == TX_DATA && txTick) txBit <= txBit + 3'd1;
            if (txPop) txShift <= txMem[txRdPtr[AW-1:0]];
            else if (txState == TX_DATA && txTick) txShift <= txShift >> 1;
        end
    end

    always_comb begin
        txd = 1'b1;
        if (txState == TX_START) txd = 1'b0;
        if (txState == TX_DATA)  txd = txShift[0];
    end

    logic rxS1, rxS2, rxPrev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxS1   <= 1'b1;
            rxS2   <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxS1   <= rxd;
            rxS2   <= rxS1;
            rxPrev <= rxS2;
        end
    end

    rxState_t    rxState, rxNext;
    logic [15:0] rxCnt;
    logic [2:0]  rxBit;
    logic [7:0]  rxShift;
    logic        rxTick, rxPushReq, rxFrameErr;

    assign rxTick = (rxCnt == 16'd0);

    always_comb begin
        rxNext     = rxState;
        rxPushReq  = 1'b0;
        rxFrameErr = 1'b0;
        case (rxState)
            RX_IDLE: if (rxPrev && !rxS2) rxNext = RX_START;
            RX_START: if (rxTick) rxNext = rxS2 ? RX_IDLE : RX_DATA;
            RX_DATA: if (rxTick && rxBit == 3'd7) rxNext = RX_STOP;
            RX_STOP: begin
                if (rxTick) begin
                    rxPushReq  = rxS2;
                    rxFrameErr = !rxS2;
                    rxNext     = rxS2 ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: if (rxS2) rxNext = RX_IDLE;
            default: rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxState <= RX_IDLE;
            rxCnt   <= '0;
            rxBit   <= '0;
            rxShift <= '0;
        end else begin
            rxState <= rxNext;
            // First wait is half a bit so later samples land mid-bit.
            if (rxState == RX_IDLE && rxNext == RX_START)
                rxCnt <= halfMinus1;
            else if (rxTick && (rxNext == RX_DATA || rxNext == RX_STOP))
                rxCnt <= divMinus1;
            else if (!rxTick)
                rxCnt <= rxCnt - 16'd1;
            if (rxState == RX_START) rxBit <= '0;
            else if (rxState == RX_DATA && rxTick) rxBit <= rxBit + 3'd1;
            if (rxState == RX_DATA && rxTick) rxShift <= {rxS2, rxShift[7:1]};
        end
    end

    logic [7:0]  rxMem [FIFO_DEPTH];
    logic [AW:0] rxWrPtr, rxRdPtr;
    logic        rxFull, rxEmpty, rxPush, rxPop;

    assign rxEmpty = (rxWrPtr == rxRdPtr);
    assign rxFull  = (rxWrPtr[AW] != rxRdPtr[AW])
                  && (rxWrPtr[AW-1:0] == rxRdPtr[AW-1:0]);
    assign rxPop   = isData && re && !rxEmpty;
    assign rxPush  = rxPushReq && (!rxFull || rxPop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
        end else begin
            if (rxPush) rxWrPtr <= rxWrPtr + PTR_ONE;
            if (rxPop)  rxRdPtr <= rxRdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rxPush) rxMem[rxWrPtr[AW-1:0]] <= rxShift;
    end

    logic overrun, frameErr, statusWr;
    assign statusWr = isStatus && we && wrMask[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            if (rxPushReq && rxFull && !rxPop) overrun <= 1'b1;
            else if (statusWr && writeData[4]) overrun <= 1'b0;
            if (rxFrameErr) frameErr <= 1'b1;
            else if (statusWr && writeData[5]) frameErr <= 1'b0;
        end
    end

    logic txBusy;
    assign txBusy = (txState != TX_IDLE);
    assign irq    = !rxEmpty || overrun || frameErr;

    always_comb begin
        readData = '0;
        unique case (1'b1)
            isData:   readData = {24'b0, rxEmpty ? 8'h00 : rxMem[rxRdPtr[AW-1:0]]};
            isStatus: readData = {25'b0, txBusy, frameErr, overrun,
                                  rxFull, rxEmpty, txEmpty, txFull};
            isDiv:    readData = {16'b0, divReg};
            default:  readData = '0;
        endcase
    end
endmodule
